mem_io_responder: RTL and testbench

Responder end of the CPU's byte-wide memory bus: accepts the address/data/write-strobe the CPU drives each cycle and returns read data one cycle later. Decodes RAM versus memory-mapped I/O at `0x3xxxx`. Drives an external synchronous RAM and buffers UART TX/RX bytes in FIFOs. Provides the free-running cycle counter and the program-stop signal.

---
 rtl/mem_io_pkg.sv | 19 +
 rtl/byte_fifo.sv | 62 ++++++
 rtl/mem_io_responder.sv | 157 +++++++++++++++
 tb/tb_mem_io_responder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_pkg
// Description : Address map and shared constants for the CPU memory/IO responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_io_pkg;

    localparam logic [1:0]  IO_SEL   = 2'b11;
    localparam logic [17:0] IO_UART  = 18'h30000;
    localparam logic [17:0] IO_CLOCK = 18'h30004;
    localparam int          BYTE_W   = 8;

    function automatic logic is_io(input logic [17:0] addr);
        return addr[17:16] == IO_SEL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Show-ahead synchronous FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo
    import mem_io_pkg::*;
#(
    parameter int DEPTH_W = 4,
    parameter int WIDTH   = BYTE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
    output logic               full,
    output logic               empty,
    output logic [DEPTH_W:0]   count
);

    localparam int DEPTH = 1 << DEPTH_W;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [DEPTH_W-1:0] r_wr_ptr;
    logic [DEPTH_W-1:0] r_rd_ptr;
    logic [DEPTH_W:0]   r_count;
    logic               w_do_pop;
    logic               w_do_push;

    assign full      = r_count[DEPTH_W];
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + DEPTH_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (DEPTH_W + 1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_responder
// Description : CPU byte-bus responder: RAM pass-through, UART FIFOs, cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH_WIDTH = 4,
    parameter int RX_DEPTH_WIDTH = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [31:0]               cpu_a,
    input  logic [7:0]                cpu_din,
    input  logic                      cpu_wr,
    output logic [7:0]                cpu_dout,
    output logic                      io_buffer_full,
    output logic [RAM_ADDR_WIDTH-1:0] ram_a,
    output logic                      ram_we,
    output logic [7:0]                ram_din,
    input  logic [7:0]                ram_dout,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic                      rx_ready,
    output logic                      program_stop,
    output logic                      tx_overflow
);

    localparam logic [TX_DEPTH_WIDTH:0] TX_NEAR_FULL =
        (TX_DEPTH_WIDTH + 1)'((1 << TX_DEPTH_WIDTH) - 2);

    logic [17:0]               w_addr;
    logic                      w_io;
    logic                      w_unused_addr_hi;
    logic                      w_uart_wr;
    logic                      w_stop_wr;
    logic                      w_clock_rd;
    logic [7:0]                w_io_rdata;

    logic                      w_tx_push;
    logic                      w_tx_pop;
    logic [7:0]                w_tx_din;
    logic                      w_tx_full;
    logic                      w_tx_empty;
    logic [TX_DEPTH_WIDTH:0]   w_tx_count;

    logic                      w_rx_push;
    logic                      w_rx_pop;
    logic [7:0]                w_rx_dout;
    logic                      w_rx_full;
    logic                      w_rx_empty;
    logic [RX_DEPTH_WIDTH:0]   w_unused_rx_count;

    logic [31:0]               r_counter;
    logic [31:0]               r_snap;
    logic                      r_sel_io;
    logic [7:0]                r_io_rdata;
    logic                      r_program_stop;
    logic                      r_tx_overflow;

    assign w_addr           = cpu_a[17:0];
    assign w_io             = is_io(w_addr);
    assign w_unused_addr_hi = ^cpu_a[31:18];

    assign ram_a   = cpu_a[RAM_ADDR_WIDTH-1:0];
    assign ram_din = cpu_din;
    assign ram_we  = cpu_wr & ~w_io;

    assign w_uart_wr  = w_io & cpu_wr & (w_addr == IO_UART) & (cpu_din != 8'h00);
    assign w_stop_wr  = w_io & cpu_wr & (w_addr == IO_CLOCK);
    assign w_clock_rd = w_io & ~cpu_wr & (w_addr == IO_CLOCK);

    assign w_tx_push = w_uart_wr | w_stop_wr;
    assign w_tx_din  = w_stop_wr ? 8'h00 : cpu_din;
    assign w_tx_pop  = tx_valid & tx_ready;
    assign tx_valid  = ~w_tx_empty;
    assign io_buffer_full = (w_tx_count >= TX_NEAR_FULL);

    assign rx_ready  = ~w_rx_full;
    assign w_rx_push = rx_valid & rx_ready;
    // Any CPU read cycle on the UART address consumes an RX byte.
    assign w_rx_pop  = w_io & ~cpu_wr & (w_addr == IO_UART);

    byte_fifo #(
        .DEPTH_W (TX_DEPTH_WIDTH),
        .WIDTH   (BYTE_W)
    ) u_tx_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (w_tx_push),
        .pop   (w_tx_pop),
        .din   (w_tx_din),
        .dout  (tx_data),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count)
    );

    byte_fifo #(
        .DEPTH_W (RX_DEPTH_WIDTH),
        .WIDTH   (BYTE_W)
    ) u_rx_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (w_rx_push),
        .pop   (w_rx_pop),
        .din   (rx_data),
        .dout  (w_rx_dout),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (w_unused_rx_count)
    );

    always_comb begin
        w_io_rdata = 8'h00;
        if (w_io && !cpu_wr) begin
            case (w_addr)
                IO_UART:          w_io_rdata = w_rx_empty ? 8'h00 : w_rx_dout;
                IO_CLOCK:         w_io_rdata = r_counter[7:0];
                IO_CLOCK + 18'd1: w_io_rdata = r_snap[15:8];
                IO_CLOCK + 18'd2: w_io_rdata = r_snap[23:16];
                IO_CLOCK + 18'd3: w_io_rdata = r_snap[31:24];
                default:          w_io_rdata = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_counter      <= '0;
            r_snap         <= '0;
            r_sel_io       <= 1'b1;
            r_io_rdata     <= '0;
            r_program_stop <= 1'b0;
            r_tx_overflow  <= 1'b0;
        end else begin
            r_counter  <= r_counter + 32'd1;
            r_sel_io   <= w_io;
            r_io_rdata <= w_io_rdata;
            if (w_clock_rd) r_snap <= r_counter;
            if (w_stop_wr)  r_program_stop <= 1'b1;
            if (w_tx_push && w_tx_full && !w_tx_pop) r_tx_overflow <= 1'b1;
        end
    end

    assign cpu_dout     = r_sel_io ? r_io_rdata : ram_dout;
    assign program_stop = r_program_stop;
    assign tx_overflow  = r_tx_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_io_responder
// Description : Directed + random self-checking bench with a queue-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_din;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_stop;
    logic        tx_overflow;

    mem_io_responder #(
        .RAM_ADDR_WIDTH (17),
        .TX_DEPTH_WIDTH (4),
        .RX_DEPTH_WIDTH (4)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .cpu_a          (cpu_a),
        .cpu_din        (cpu_din),
        .cpu_wr         (cpu_wr),
        .cpu_dout       (cpu_dout),
        .io_buffer_full (io_buffer_full),
        .ram_a          (ram_a),
        .ram_we         (ram_we),
        .ram_din        (ram_din),
        .ram_dout       (ram_dout),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .program_stop   (program_stop),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    // External synchronous RAM, read-before-write, one cycle latency
    logic [7:0] ram_mem [0:(1<<17)-1];
    always @(posedge clk_in) begin
        if (ram_we) ram_mem[ram_a] <= ram_din;
        ram_dout <= ram_mem[ram_a];
    end

    logic [7:0] tx_seen [$];
    int         we_cnt;
    always @(posedge clk_in) begin
        if (!rst_in && tx_valid && tx_ready) tx_seen.push_back(tx_data);
        if (!rst_in && ram_we) we_cnt <= we_cnt + 1;
    end

    // Reference model state
    logic [7:0]  tx_q [$];
    logic [7:0]  rx_q [$];
    logic [7:0]  ram_m [int];
    logic [31:0] m_cnt;
    logic [31:0] m_snap;
    logic        m_ovf;
    logic        m_stop;
    logic [7:0]  m_dout;
    logic        m_dout_chk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle with the inputs currently driven: check, then advance the model.
    task automatic cycle();
        logic [17:0] a;
        logic        io;
        logic        tx_pop;
        logic        tx_push;
        logic [7:0]  tx_byte;
        int          tx_pre;
        int          rx_pre;
        @(negedge clk_in);
        a  = cpu_a[17:0];
        io = (a[17:16] == 2'b11);
        if (m_dout_chk) chk("cpu_dout", cpu_dout, m_dout);
        chk("tx_valid", tx_valid, tx_q.size() != 0);
        if (tx_q.size() != 0) chk("tx_data", tx_data, tx_q[0]);
        chk("rx_ready", rx_ready, rx_q.size() < 16);
        chk("io_buffer_full", io_buffer_full, tx_q.size() >= 14);
        chk("tx_overflow", tx_overflow, m_ovf);
        chk("program_stop", program_stop, m_stop);
        chk("ram_we", ram_we, !io && cpu_wr);
        if (!io) chk("ram_a", ram_a, a[16:0]);

        tx_pre  = tx_q.size();
        rx_pre  = rx_q.size();
        tx_pop  = (tx_pre != 0) && tx_ready;
        tx_push = 1'b0;
        tx_byte = 8'h00;
        m_dout_chk = !cpu_wr;
        m_dout     = 8'h00;
        if (!io) begin
            if (cpu_wr) ram_m[int'(a[16:0])] = cpu_din;
            else if (ram_m.exists(int'(a[16:0]))) m_dout = ram_m[int'(a[16:0])];
        end else if (cpu_wr) begin
            if (a == 18'h30000 && cpu_din != 8'h00) begin
                tx_push = 1'b1;
                tx_byte = cpu_din;
            end else if (a == 18'h30004) begin
                tx_push = 1'b1;
                m_stop  = 1'b1;
            end
        end else begin
            case (a)
                18'h30000: if (rx_pre != 0) m_dout = rx_q.pop_front();
                18'h30004: begin m_dout = m_cnt[7:0]; m_snap = m_cnt; end
                18'h30005: m_dout = m_snap[15:8];
                18'h30006: m_dout = m_snap[23:16];
                18'h30007: m_dout = m_snap[31:24];
                default:   m_dout = 8'h00;
            endcase
        end
        if (tx_pop) void'(tx_q.pop_front());
        if (tx_push) begin
            if (tx_pre < 16 || tx_pop) tx_q.push_back(tx_byte);
            else m_ovf = 1'b1;
        end
        if (rx_valid && rx_pre < 16) rx_q.push_back(rx_data);
        m_cnt = m_cnt + 32'd1;
        @(posedge clk_in);
        #1;
    endtask

    task automatic acc(input logic [31:0] a, input logic wr, input logic [7:0] d);
        cpu_a   = a;
        cpu_wr  = wr;
        cpu_din = d;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) acc(32'h0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst_in   = 1'b1;
        cpu_a    = '0;
        cpu_wr   = 1'b0;
        cpu_din  = '0;
        rx_valid = 1'b0;
        rx_data  = '0;
        tx_ready = 1'b0;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        tx_q.delete();
        rx_q.delete();
        m_cnt      = '0;
        m_snap     = '0;
        m_ovf      = 1'b0;
        m_stop     = 1'b0;
        m_dout     = 8'h00;
        m_dout_chk = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        we_cnt = 0;
        for (int k = 0; k < (1 << 17); k++) ram_mem[k] = 8'h00;

        // Reset state
        do_reset();
        chk("reset cpu_dout", cpu_dout, 8'h00);
        chk("reset tx_valid", tx_valid, 1'b0);
        chk("reset rx_ready", rx_ready, 1'b1);
        chk("reset io_buffer_full", io_buffer_full, 1'b0);
        chk("reset program_stop", program_stop, 1'b0);
        chk("reset tx_overflow", tx_overflow, 1'b0);

        // RAM write then read back
        we_cnt = 0;
        acc(32'h0001_0010 & 32'h0000_FFFF, 1'b1, 8'hA5);
        acc(32'h0000_0010, 1'b0, 8'h00);
        chk("ram readback", cpu_dout, 8'hA5);
        chk("ram_we pulses", we_cnt, 1);

        // UART TX: nonzero byte sent, zero byte ignored
        tx_ready = 1'b1;
        tx_seen.delete();
        acc(32'h0003_0000, 1'b1, 8'h41);
        acc(32'h0003_0000, 1'b1, 8'h00);
        idle(3);
        chk("tx single count", tx_seen.size(), 1);
        if (tx_seen.size() > 0) chk("tx single byte", tx_seen[0], 8'h41);
        chk("tx no overflow", tx_overflow, 1'b0);

        // TX fill past capacity with the UART stalled
        tx_ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            acc(32'h0003_0000, 1'b1, 8'(i));
            if (i == 13) chk("near full after 13", io_buffer_full, 1'b0);
            if (i == 14) chk("near full after 14", io_buffer_full, 1'b1);
        end
        chk("overflow after 17", tx_overflow, 1'b1);
        tx_seen.delete();
        tx_ready = 1'b1;
        idle(20);
        chk("drain count", tx_seen.size(), 16);
        for (int i = 0; i < 16 && i < tx_seen.size(); i++)
            chk("drain order", tx_seen[i], 8'(i + 1));

        // Counter read and snapshot
        do_reset();
        while (m_cnt != 32'h0000_0164) idle(1);
        acc(32'h0003_0004, 1'b0, 8'h00);
        chk("clock byte0", cpu_dout, 8'h64);
        acc(32'h0003_0005, 1'b0, 8'h00);
        chk("snap byte1", cpu_dout, 8'h01);
        acc(32'h0003_0006, 1'b0, 8'h00);
        chk("snap byte2", cpu_dout, 8'h00);
        acc(32'h0003_0007, 1'b0, 8'h00);
        chk("snap byte3", cpu_dout, 8'h00);

        // RX receive and pop, including push into empty on a pop cycle
        do_reset();
        rx_data  = 8'h31;
        rx_valid = 1'b1;
        idle(1);
        rx_valid = 1'b0;
        acc(32'h0003_0000, 1'b0, 8'h00);
        chk("rx first pop", cpu_dout, 8'h31);
        acc(32'h0003_0000, 1'b0, 8'h00);
        chk("rx empty pop", cpu_dout, 8'h00);
        chk("rx_ready held", rx_ready, 1'b1);
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        acc(32'h0003_0000, 1'b0, 8'h00);
        chk("rx same-cycle pop", cpu_dout, 8'h00);
        rx_valid = 1'b0;
        acc(32'h0003_0000, 1'b0, 8'h00);
        chk("rx queued byte", cpu_dout, 8'h5A);

        // Program stop and reset with bytes queued
        tx_ready = 1'b1;
        tx_seen.delete();
        acc(32'h0003_0004, 1'b1, 8'h77);
        idle(3);
        chk("stop tx count", tx_seen.size(), 1);
        if (tx_seen.size() > 0) chk("stop tx byte", tx_seen[0], 8'h00);
        chk("program_stop set", program_stop, 1'b1);
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) acc(32'h0003_0000, 1'b1, 8'h11);
        idle(2);
        chk("program_stop sticky", program_stop, 1'b1);
        chk("tx queued", tx_valid, 1'b1);
        do_reset();
        chk("reset clears tx", tx_valid, 1'b0);
        chk("reset clears stop", program_stop, 1'b0);
        acc(32'h0003_0004, 1'b0, 8'h00);
        chk("counter restart", cpu_dout, 8'h00);

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            logic [17:0] ra;
            logic        rw;
            logic [7:0]  rd;
            int          kind;
            kind = $urandom_range(0, 9);
            rw   = 1'b0;
            rd   = 8'($urandom);
            case (kind)
                0, 1: begin ra = 18'($urandom_range(0, 63)); rw = 1'b1; end
                2:    ra = 18'($urandom_range(0, 63));
                3:    begin ra = 18'h30000; rw = 1'b1; if ($urandom_range(0, 3) == 0) rd = 8'h00; end
                4:    ra = 18'h30000;
                5:    ra = 18'h30004;
                6:    ra = 18'h30005 + 18'($urandom_range(0, 2));
                7:    begin
                          case ($urandom_range(0, 4))
                              0: ra = 18'h30001;
                              1: ra = 18'h30002;
                              2: ra = 18'h30003;
                              3: ra = 18'h30008;
                              default: ra = 18'h3FFFF;
                          endcase
                          rw = 1'($urandom);
                      end
                8:    begin ra = 18'h30004; rw = ($urandom_range(0, 15) == 0); end
                default: ra = 18'h0 | 18'($urandom_range(0, 63));
            endcase
            tx_ready = 1'($urandom);
            rx_valid = 1'($urandom);
            rx_data  = 8'($urandom);
            acc({14'($urandom), ra}, rw, rd);
        end
        rx_valid = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
